// File: rtl/nexi_uart_fifo_wb.sv
// Wishbone-slave UART: programmable 16x baud divisor, TX/RX byte FIFOs,
// sticky line-status flags and level-based maskable interrupt.

module nexi_uart_fifo_wb_fifo #(
    parameter int AW = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push,
    input  logic [7:0]  wdata,
    input  logic        pop,
    output logic [7:0]  rdata,
    output logic [AW:0] level
);
    localparam int DEPTH = 1 << AW;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        empty;
    logic        full;
    logic        do_push;
    logic        do_pop;

    assign level   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A same-cycle pop frees the slot the push lands in, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end
endmodule

module nexi_uart_fifo_wb #(
    parameter int                   FIFO_AW   = 4,
    parameter int                   DIV_WIDTH = 16,
    parameter logic [DIV_WIDTH-1:0] DIV_RESET = 16'd27,
    parameter int                   RX_THRESH = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cyc_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [2:0] addr_i,
    input  logic [7:0] data_i,
    output logic       ack_o,
    output logic [7:0] data_o,
    output logic       irq_o,
    input  logic       rx_pin,
    output logic       tx_pin
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [DIV_WIDTH-1:0] DIV_LO_MASK = DIV_WIDTH'(16'h00FF);
    localparam logic [DIV_WIDTH-1:0] DIV_HI_MASK = DIV_WIDTH'(16'hFF00);
    localparam logic [FIFO_AW:0]     RX_THR      = (FIFO_AW + 1)'(RX_THRESH);

    // Bus decode
    logic wb_req;
    logic wr_req;
    logic rd_req;
    logic thr_push;
    logic rbr_pop;
    logic lsr_clr;
    logic div_wr;

    assign wb_req   = cyc_i && stb_i && !ack_o;
    assign wr_req   = wb_req && we_i;
    assign rd_req   = wb_req && !we_i;
    assign thr_push = wr_req && (addr_i == 3'd0);
    assign lsr_clr  = rd_req && (addr_i == 3'd3);
    assign div_wr   = wr_req && ((addr_i == 3'd4) || (addr_i == 3'd5));

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic                 tick16;
    logic [2:0]           ier_q;

    assign tick16 = (baud_cnt == div_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q    <= DIV_RESET;
            baud_cnt <= '0;
            ier_q    <= '0;
        end else begin
            if (wr_req && (addr_i == 3'd4)) begin
                div_q <= (div_q & ~DIV_LO_MASK) | DIV_WIDTH'(data_i);
            end
            if (wr_req && (addr_i == 3'd5)) begin
                div_q <= (div_q & ~DIV_HI_MASK) | DIV_WIDTH'({data_i, 8'h00});
            end
            if (wr_req && (addr_i == 3'd1)) begin
                ier_q <= data_i[2:0];
            end
            if (div_wr || tick16) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

    // FIFOs
    logic [FIFO_AW:0] tx_level;
    logic [FIFO_AW:0] rx_level;
    logic [7:0]       tx_rdata;
    logic [7:0]       rx_rdata;
    logic             tx_empty;
    logic             tx_full;
    logic             rx_empty;
    logic             rx_full;
    logic             tx_pop;
    logic             rx_push;
    logic [7:0]       rx_shift;

    assign tx_empty = (tx_level == '0);
    assign tx_full  = tx_level[FIFO_AW];
    assign rx_empty = (rx_level == '0);
    assign rx_full  = rx_level[FIFO_AW];
    assign rbr_pop  = rd_req && (addr_i == 3'd0) && !rx_empty;

    nexi_uart_fifo_wb_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (thr_push),
        .wdata  (data_i),
        .pop    (tx_pop),
        .rdata  (tx_rdata),
        .level  (tx_level)
    );

    nexi_uart_fifo_wb_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (rx_push),
        .wdata  (rx_shift),
        .pop    (rbr_pop),
        .rdata  (rx_rdata),
        .level  (rx_level)
    );

    // Transmitter: each state lasts 16 ticks; frames start on a tick boundary.
    logic [1:0] tx_state;
    logic [3:0] tx_tcnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_shift;
    logic       tx_bit_end;
    logic       tx_idle_line;

    assign tx_bit_end   = tick16 && (tx_tcnt == 4'd15);
    assign tx_pop       = !tx_empty && ((tick16 && (tx_state == ST_IDLE)) ||
                                        (tx_bit_end && (tx_state == ST_STOP)));
    assign tx_idle_line = tx_empty && (tx_state == ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state <= ST_IDLE;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_pin   <= 1'b1;
        end else begin
            if (tick16) begin
                tx_tcnt <= tx_tcnt + 1'b1;
            end
            case (tx_state)
                ST_IDLE: begin
                    if (tx_pop) begin
                        tx_state <= ST_START;
                        tx_shift <= tx_rdata;
                        tx_tcnt  <= '0;
                        tx_pin   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_bit_end) begin
                        tx_state <= ST_DATA;
                        tx_bit   <= '0;
                        tx_pin   <= tx_shift[0];
                    end
                end
                ST_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit == 3'd7) begin
                            tx_state <= ST_STOP;
                            tx_pin   <= 1'b1;
                        end else begin
                            tx_shift <= tx_shift >> 1;
                            tx_pin   <= tx_shift[1];
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end
                end
                default: begin
                    if (tx_bit_end) begin
                        if (tx_pop) begin
                            tx_state <= ST_START;
                            tx_shift <= tx_rdata;
                            tx_tcnt  <= '0;
                            tx_pin   <= 1'b0;
                        end else begin
                            tx_state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Receiver: 2-flop synchroniser, edge detect, mid-bit sampling.
    logic       rx_meta_p0;
    logic       rx_sync_p1;
    logic       rx_dly_p2;
    logic [1:0] rx_state;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bit;
    logic       rx_fall;
    logic       ferr_set;
    logic       rxovr_set;
    logic       txovf_set;

    assign rx_fall   = rx_dly_p2 && !rx_sync_p1;
    assign rx_push   = (rx_state == ST_STOP) && tick16 && (rx_tcnt == 4'd15);
    assign ferr_set  = rx_push && !rx_sync_p1;
    assign rxovr_set = rx_push && rx_full && !rbr_pop;
    assign txovf_set = thr_push && tx_full && !tx_pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_dly_p2  <= 1'b1;
            rx_state   <= ST_IDLE;
            rx_tcnt    <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
        end else begin
            rx_meta_p0 <= rx_pin;
            rx_sync_p1 <= rx_meta_p0;
            rx_dly_p2  <= rx_sync_p1;
            if (tick16) begin
                rx_tcnt <= rx_tcnt + 1'b1;
            end
            case (rx_state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= ST_START;
                        rx_tcnt  <= '0;
                    end
                end
                ST_START: begin
                    // Half a bit in: a line that is high again was only a glitch.
                    if (tick16 && (rx_tcnt == 4'd7)) begin
                        if (rx_sync_p1) begin
                            rx_state <= ST_IDLE;
                        end else begin
                            rx_state <= ST_DATA;
                            rx_tcnt  <= '0;
                            rx_bit   <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick16 && (rx_tcnt == 4'd15)) begin
                        rx_shift <= {rx_sync_p1, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end
                end
                default: begin
                    if (rx_push) begin
                        rx_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Status, interrupt and bus response
    logic       rxovr_q;
    logic       ferr_q;
    logic       txovf_q;
    logic [7:0] lsr;
    logic [2:0] isr;
    logic [7:0] rd_data;

    assign lsr = {1'b0, txovf_q, ferr_q, rxovr_q, tx_full, tx_idle_line, rx_full, !rx_empty};
    assign isr = {rxovr_q || ferr_q || txovf_q, tx_idle_line, rx_level >= RX_THR};

    always_comb begin
        rd_data = 8'h00;
        case (addr_i)
            3'd0:    rd_data = rx_empty ? 8'h00 : rx_rdata;
            3'd1:    rd_data = {5'd0, ier_q};
            3'd2:    rd_data = {5'd0, isr};
            3'd3:    rd_data = lsr;
            3'd4:    rd_data = div_q[7:0];
            3'd5:    rd_data = 8'(div_q >> 8);
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxovr_q <= 1'b0;
            ferr_q  <= 1'b0;
            txovf_q <= 1'b0;
            ack_o   <= 1'b0;
            data_o  <= 8'h00;
            irq_o   <= 1'b0;
        end else begin
            rxovr_q <= rxovr_set || (rxovr_q && !lsr_clr);
            ferr_q  <= ferr_set  || (ferr_q  && !lsr_clr);
            txovf_q <= txovf_set || (txovf_q && !lsr_clr);
            ack_o   <= wb_req;
            data_o  <= rd_req ? rd_data : 8'h00;
            irq_o   <= |(isr & ier_q);
        end
    end
endmodule

// File: tb/tb_nexi_uart_fifo_wb.sv
// Directed bench for nexi_uart_fifo_wb: register map, TX framing, FIFO limits,
// loopback receive, RX overrun/framing/glitch handling and async reset.

module tb_nexi_uart_fifo_wb;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       cyc_i = 1'b0;
    logic       stb_i = 1'b0;
    logic       we_i = 1'b0;
    logic [2:0] addr_i = 3'd0;
    logic [7:0] data_i = 8'h00;
    logic       ack_o;
    logic [7:0] data_o;
    logic       irq_o;
    logic       rx_pin;
    logic       tx_pin;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    assign rx_pin = loop_en ? tx_pin : rx_drv;

    always #5 clk_i = ~clk_i;

    nexi_uart_fifo_wb dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .ack_o  (ack_o),
        .data_o (data_o),
        .irq_o  (irq_o),
        .rx_pin (rx_pin),
        .tx_pin (tx_pin)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wb_xfer(input logic w, input logic [2:0] a, input logic [7:0] d,
                           output logic [7:0] q);
        int n;
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; addr_i = a; data_i = d;
        n = 0;
        do begin
            @(posedge clk_i); #1; n++;
        end while (!ack_o && n < 20);
        q = data_o;
        if (!ack_o) begin
            n_checks++;
            $display("FAIL wb_ack: no ack at addr %0d within %0d cycles", a, n);
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            rx_drv = (i == 0) ? 1'b0 : ((i == 9) ? stop : b[i-1]);
            repeat (15) @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        logic [7:0] q;
        logic [7:0] exp_rd [8];
        exp_rd = '{8'h00, 8'h00, 8'h02, 8'h04, 8'h1B, 8'h00, 8'h00, 8'h00};
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if ({ack_o, data_o, irq_o, tx_pin} !== {1'b0, 8'h00, 1'b0, 1'b1})
            $display("FAIL reset_outputs: got ack=%b data=%h irq=%b tx=%b required 0/00/0/1",
                     ack_o, data_o, irq_o, tx_pin);
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int a = 0; a < 8; a++) begin
            wb_xfer(1'b0, 3'(a), 8'h00, q);
            n_checks++;
            if (q !== exp_rd[a])
                $display("FAIL reset_read_%0d: got %h required %h", a, q, exp_rd[a]);
            else n_pass++;
        end
        // Read-only and unmapped addresses ignore writes.
        wb_xfer(1'b1, 3'd2, 8'hFF, q);
        wb_xfer(1'b1, 3'd3, 8'hFF, q);
        wb_xfer(1'b1, 3'd6, 8'hFF, q);
        wb_xfer(1'b0, 3'd3, 8'h00, q);
        n_checks++;
        if (q !== 8'h04) $display("FAIL lsr_write_ignored: got %h required 04", q);
        else n_pass++;
        wb_xfer(1'b0, 3'd6, 8'h00, q);
        n_checks++;
        if (q !== 8'h00) $display("FAIL addr6_write_ignored: got %h required 00", q);
        else n_pass++;
        n_checks++;
        if (irq_o !== 1'b0) $display("FAIL irq_masked: got %b required 0", irq_o);
        else n_pass++;
        // Unmasking TXEMPTY raises irq one cycle after the IER write.
        wb_xfer(1'b1, 3'd1, 8'h07, q);
        @(posedge clk_i); #1;
        n_checks++;
        if (irq_o !== 1'b1) $display("FAIL irq_txempty: got %b required 1", irq_o);
        else n_pass++;
        wb_xfer(1'b0, 3'd1, 8'h00, q);
        n_checks++;
        if (q !== 8'h07) $display("FAIL ier_readback: got %h required 07", q);
        else n_pass++;
        wb_xfer(1'b1, 3'd1, 8'h00, q);
        @(posedge clk_i); #1;
        n_checks++;
        if (irq_o !== 1'b0) $display("FAIL irq_masked_again: got %b required 0", irq_o);
        else n_pass++;
    endtask

    task automatic test_wb_timing();
        logic [3:0] acks;
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            @(posedge clk_i); #1;
            acks[i] = ack_o;
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        n_checks++;
        if (acks !== 4'b1010) $display("FAIL ack_pattern: got %b required 1010", acks);
        else n_pass++;
    endtask

    task automatic test_tx_frame();
        logic [7:0]   q;
        logic [7:0]   d;
        logic [169:0] got;
        logic [169:0] exp_v;
        int           idx;
        d = 8'hA5;
        wb_xfer(1'b1, 3'd4, 8'h00, q);
        wb_xfer(1'b1, 3'd0, d, q);
        for (int k = 1; k <= 170; k++) begin
            @(posedge clk_i); #1;
            got[k-1] = tx_pin;
            idx = (k - 1) / 16;
            if (idx == 0) exp_v[k-1] = 1'b0;
            else if (idx >= 9) exp_v[k-1] = 1'b1;
            else exp_v[k-1] = d[idx-1];
        end
        n_checks++;
        if (got[15:0] !== exp_v[15:0])
            $display("FAIL tx_start: got %h required %h", got[15:0], exp_v[15:0]);
        else n_pass++;
        n_checks++;
        if (got[143:16] !== exp_v[143:16])
            $display("FAIL tx_data: got %h required %h", got[143:16], exp_v[143:16]);
        else n_pass++;
        n_checks++;
        if (got[169:144] !== exp_v[169:144])
            $display("FAIL tx_stop_idle: got %h required %h", got[169:144], exp_v[169:144]);
        else n_pass++;
        wb_xfer(1'b0, 3'd3, 8'h00, q);
        n_checks++;
        if (q !== 8'h04) $display("FAIL tx_done_lsr: got %h required 04", q);
        else n_pass++;
    endtask

    task automatic test_tx_overflow();
        logic [7:0] q;
        logic [7:0] dat [17];
        int         errs [17];
        int         f;
        int         idx;
        logic       e;
        for (int i = 0; i < 17; i++) begin
            dat[i]  = 8'(i * 37 + 5);
            errs[i] = 0;
        end
        // A slow divisor keeps the transmitter from draining while the FIFO fills.
        wb_xfer(1'b1, 3'd4, 8'hFF, q);
        for (int i = 0; i < 17; i++) wb_xfer(1'b1, 3'd0, dat[i], q);
        wb_xfer(1'b0, 3'd3, 8'h00, q);
        n_checks++;
        if (q !== 8'h48) $display("FAIL lsr_txovf: got %h required 48", q);
        else n_pass++;
        wb_xfer(1'b0, 3'd3, 8'h00, q);
        n_checks++;
        if (q !== 8'h08) $display("FAIL lsr_txovf_cleared: got %h required 08", q);
        else n_pass++;
        wb_xfer(1'b1, 3'd4, 8'h00, q);
        for (int k = 1; k <= 2580; k++) begin
            @(posedge clk_i); #1;
            f   = (k - 1) / 160;
            idx = ((k - 1) % 160) / 16;
            if (f >= 16 || idx == 9) e = 1'b1;
            else if (idx == 0) e = 1'b0;
            else e = dat[f][idx-1];
            if (tx_pin !== e) errs[f]++;
        end
        for (int i = 0; i < 17; i++) begin
            n_checks++;
            if (errs[i] != 0)
                $display("FAIL tx_burst_frame_%0d: %0d bad cycles, required 0", i, errs[i]);
            else n_pass++;
        end
        wb_xfer(1'b0, 3'd3, 8'h00, q);
        n_checks++;
        if (q !== 8'h04) $display("FAIL tx_burst_done_lsr: got %h required 04", q);
        else n_pass++;
    endtask

    task automatic test_loopback();
        logic [7:0] q;
        int         rise_k;
        logic       irq_early;
        loop_en = 1'b1;
        wb_xfer(1'b1, 3'd1, 8'h01, q);
        wb_xfer(1'b1, 3'd0, 8'h3C, q);
        rise_k = 0;
        irq_early = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk_i); #1;
            if (k == 140) irq_early = irq_o;
            if (irq_o === 1'b1 && rise_k == 0) rise_k = k;
        end
        n_checks++;
        if (irq_early !== 1'b0) $display("FAIL loop_irq_early: got %b required 0", irq_early);
        else n_pass++;
        n_checks++;
        if (rise_k <= 144 || rise_k >= 200)
            $display("FAIL loop_irq_rise: rose at cycle %0d, required 145..199", rise_k);
        else n_pass++;
        wb_xfer(1'b0, 3'd0, 8'h00, q);
        n_checks++;
        if (q !== 8'h3C) $display("FAIL loop_rbr: got %h required 3c", q);
        else n_pass++;
        n_checks++;
        if (irq_o !== 1'b1) $display("FAIL loop_irq_at_pop: got %b required 1", irq_o);
        else n_pass++;
        @(posedge clk_i); #1;
        n_checks++;
        if (irq_o !== 1'b0) $display("FAIL loop_irq_after_pop: got %b required 0", irq_o);
        else n_pass++;
        wb_xfer(1'b0, 3'd0, 8'h00, q);
        n_checks++;
        if (q !== 8'h00) $display("FAIL loop_rbr_empty: got %h required 00", q);
        else n_pass++;
        wb_xfer(1'b1, 3'd1, 8'h00, q);
        rx_drv  = 1'b1;
        loop_en = 1'b0;
    endtask

    task automatic test_rx_overrun();
        logic [7:0] q;
        logic [7:0] dat [17];
        int         bad;
        for (int i = 0; i < 17; i++) dat[i] = 8'(i * 29 + 11);
        for (int i = 0; i < 17; i++) rx_frame(dat[i], 1'b1);
        @(negedge clk_i);
        rx_drv = 1'b1;
        repeat (5) @(posedge clk_i);
        wb_xfer(1'b0, 3'd3, 8'h00, q);
        n_checks++;
        if (q !== 8'h17) $display("FAIL rx_full_lsr: got %h required 17", q);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            wb_xfer(1'b0, 3'd0, 8'h00, q);
            n_checks++;
            if (q !== dat[i]) $display("FAIL rx_order_%0d: got %h required %h", i, q, dat[i]);
            else n_pass++;
        end
        wb_xfer(1'b0, 3'd0, 8'h00, q);
        n_checks++;
        if (q !== 8'h00) $display("FAIL rx_17th_absent: got %h required 00", q);
        else n_pass++;
        wb_xfer(1'b0, 3'd3, 8'h00, q);
        n_checks++;
        if (q !== 8'h04) $display("FAIL rx_ovr_cleared: got %h required 04", q);
        else n_pass++;
    endtask

    task automatic test_rx_errors();
        logic [7:0] q;
        rx_frame(8'h5A, 1'b0);
        @(negedge clk_i);
        rx_drv = 1'b1;
        repeat (5) @(posedge clk_i);
        wb_xfer(1'b0, 3'd2, 8'h00, q);
        n_checks++;
        if (q !== 8'h07) $display("FAIL ferr_isr: got %h required 07", q);
        else n_pass++;
        wb_xfer(1'b0, 3'd3, 8'h00, q);
        n_checks++;
        if (q !== 8'h25) $display("FAIL ferr_lsr: got %h required 25", q);
        else n_pass++;
        wb_xfer(1'b0, 3'd0, 8'h00, q);
        n_checks++;
        if (q !== 8'h5A) $display("FAIL ferr_byte: got %h required 5a", q);
        else n_pass++;
        @(negedge clk_i);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk_i);
        rx_drv = 1'b1;
        repeat (40) @(posedge clk_i);
        wb_xfer(1'b0, 3'd3, 8'h00, q);
        n_checks++;
        if (q !== 8'h04) $display("FAIL glitch_lsr: got %h required 04", q);
        else n_pass++;
        wb_xfer(1'b0, 3'd0, 8'h00, q);
        n_checks++;
        if (q !== 8'h00) $display("FAIL glitch_no_byte: got %h required 00", q);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] q;
        int         lows;
        wb_xfer(1'b1, 3'd0, 8'h81, q);
        wb_xfer(1'b1, 3'd0, 8'h42, q);
        repeat (48) @(posedge clk_i);
        #1;
        n_checks++;
        if (tx_pin !== 1'b0) $display("FAIL midframe_low: got %b required 0", tx_pin);
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (tx_pin !== 1'b1) $display("FAIL reset_tx_async: got %b required 1", tx_pin);
        else n_pass++;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        lows = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk_i); #1;
            if (tx_pin !== 1'b1) lows++;
        end
        n_checks++;
        if (lows != 0) $display("FAIL reset_fifo_lost: %0d low cycles, required 0", lows);
        else n_pass++;
        wb_xfer(1'b0, 3'd3, 8'h00, q);
        n_checks++;
        if (q !== 8'h04) $display("FAIL reset_lsr: got %h required 04", q);
        else n_pass++;
        wb_xfer(1'b0, 3'd4, 8'h00, q);
        n_checks++;
        if (q !== 8'h1B) $display("FAIL reset_div: got %h required 1b", q);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_wb_timing();
        test_tx_frame();
        test_tx_overflow();
        test_loopback();
        test_rx_overrun();
        test_rx_errors();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
